// File: rtl/i2c_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_fifo
// Description : Single-clock FIFO between the APB bridge and the I2C core.
//               Used for both the TX path (bridge pushes, core pops) and the
//               RX path (core pushes, bridge pops). Provides a fill level,
//               almost-full/almost-empty flags and sticky overflow/underflow
//               error flags.
//               Build option FIFO_FWFT_EN: when defined, DATA_OUT shows the
//               head word combinationally (first-word-fall-through); when not
//               defined, DATA_OUT is registered and updates the cycle after
//               an accepted pop.
// Revision    : 1.0  initial release
// ============================================================================
module i2c_sync_fifo #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CLEAR,
  input  logic              WR_ENA,
  input  logic [DWIDTH-1:0] DATA_IN,
  input  logic              RD_ENA,
  output logic [DWIDTH-1:0] DATA_OUT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [AWIDTH:0]   LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int               DEPTH     = 1 << AWIDTH;
  localparam logic [AWIDTH:0]  DEPTH_LVL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]  AF_LVL    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0]  AE_LVL    = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0]  LVL_ONE   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  // Storage array; deliberately has no reset so it maps onto plain RAM.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   level;
  logic              overflow;
  logic              underflow;

  logic              is_full;
  logic              is_empty;
  logic              push_ok;
  logic              pop_ok;
  logic              push_rej;
  logic              pop_rej;

  // Status flags come straight off the registered level, so they move one
  // cycle after the operation that changed it.
  always_comb begin
    is_full  = (level == DEPTH_LVL);
    is_empty = (level == '0);
  end

  // Accept/reject decisions use the pre-edge level only: a pop in the same
  // cycle never frees room for a push on a full FIFO, and vice versa.
  // CLEAR overrides any request in the same cycle.
  always_comb begin
    push_ok  = WR_ENA & ~is_full  & ~CLEAR;
    pop_ok   = RD_ENA & ~is_empty & ~CLEAR;
    push_rej = WR_ENA &  is_full  & ~CLEAR;
    pop_rej  = RD_ENA &  is_empty & ~CLEAR;
  end

  // Write port: store the incoming word at the write pointer on an accepted push.
  always_ff @(posedge PCLK) begin
    if (PRESETn && push_ok) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  // Pointer and level bookkeeping; reset and CLEAR both empty the FIFO.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        level <= level + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Sticky error flags: set on a rejected request, cleared only by CLEAR or reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (CLEAR) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_rej) begin
        overflow <= 1'b1;
      end
      if (pop_rej) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through to the output; a pop in the same cycle consumes
  // exactly the word currently shown. Content is meaningless while empty.
  always_comb begin
    DATA_OUT = mem[rd_ptr];
  end
`else
  logic [DWIDTH-1:0] data_q;

  // Registered read port: the popped word appears the cycle after RD_ENA and
  // is held until the next accepted pop.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      data_q <= '0;
    end else if (CLEAR) begin
      data_q <= '0;
    end else if (pop_ok) begin
      data_q <= mem[rd_ptr];
    end
  end

  // Drive the output from the read register.
  always_comb begin
    DATA_OUT = data_q;
  end
`endif

  // Output assignments derived from the registered state.
  always_comb begin
    FULL         = is_full;
    EMPTY        = is_empty;
    ALMOST_FULL  = (level >= AF_LVL);
    ALMOST_EMPTY = (level <= AE_LVL);
    LEVEL        = level;
    OVERFLOW     = overflow;
    UNDERFLOW    = underflow;
  end

endmodule
`default_nettype wire
